// File: rtl/apb_master_if.sv
// Command/response and APB bus bundle for apb_master.
//   master modport: DUT view (drives cmd_ready, rsp_*, PSEL/PENABLE/PWRITE/PADDR/PWDATA)
//   slave modport : requester + APB slave view (drives cmd_*, PRDATA/PREADY/PSLVERR)
interface apb_master_if #(
  parameter int unsigned AWIDTH = 4,
  parameter int unsigned DWIDTH = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [AWIDTH-1:0] cmd_addr;
  logic [DWIDTH-1:0] cmd_wdata;

  logic              rsp_valid;
  logic [DWIDTH-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [AWIDTH-1:0] PADDR;
  logic [DWIDTH-1:0] PWDATA;
  logic [DWIDTH-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB master: turns one accepted command into an
// IDLE->SETUP->ACCESS transfer and returns a one-cycle response pulse.
// Ports:
//   PCLK     - bus clock, rising edge
//   PRESETn  - asynchronous active-low reset
//   bus      - apb_master_if.master (command, response and APB signals)
module apb_master #(
  parameter int unsigned AWIDTH   = 4,
  parameter int unsigned DWIDTH   = 8,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  apb_master_if.master  bus
);

  localparam int unsigned CW         = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam bit          TIMEOUT_EN = (MAX_WAIT != 0);
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);
  localparam logic [CW-1:0] CNT_SAT    = {CW{1'b1}};

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [AWIDTH-1:0] paddr_q, paddr_d;
  logic [DWIDTH-1:0] pwdata_q, pwdata_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  // State and output registers
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    cnt_d         = cnt_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      IDLE: begin
        // cmd_ready_q gates acceptance so nothing is taken on the first edge after reset
        if (cmd_ready_q && bus.cmd_valid) begin
          pwrite_d  = bus.cmd_write;
          paddr_d   = bus.cmd_addr;
          pwdata_d  = bus.cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (bus.PREADY) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = bus.PSLVERR;
          rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
          rsp_timeout_d = 1'b0;
          state_d       = IDLE;
        end else if (TIMEOUT_EN && (cnt_q == WAIT_LIMIT)) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
          state_d       = IDLE;
        end else if (cnt_q != CNT_SAT) begin
          // Saturate instead of wrapping when the timeout is disabled
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: commands push expected responses,
// a negedge monitor pops and compares them when rsp_valid fires.
module tb_apb_master;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned MW = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  apb_master_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  apb_master #(.AWIDTH(AW), .DWIDTH(DW), .MAX_WAIT(MW)) dut (
    .PCLK    (clk),
    .PRESETn (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
    logic          to;
    int            acc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   wait_cycles = 0;
  int   slv_cnt = 0;
  int   acc_len = 0;
  longint accept_t = 0;
  longint prev_accept_t = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // APB slave: PREADY rises after wait_cycles low ACCESS cycles
  always @(negedge clk) begin
    if (bus.PSEL && bus.PENABLE) begin
      bus.PREADY = (slv_cnt >= wait_cycles);
      slv_cnt++;
    end else begin
      bus.PREADY = 1'b0;
      slv_cnt = 0;
    end
  end

  // Monitor: bus stability against the current item, response compare on rsp_valid
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.PSEL && sb.size() > 0) begin
        check("paddr",  32'(bus.PADDR),  32'(sb[0].addr));
        check("pwrite", 32'(bus.PWRITE), 32'(sb[0].wr));
        check("pwdata", 32'(bus.PWDATA), 32'(sb[0].wdata));
      end
      if (bus.PSEL && bus.PENABLE) acc_len++;
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          check("spurious_rsp", 32'(1), 32'(0));
        end else begin
          e = sb.pop_front();
          check("rsp_rdata",   32'(bus.rsp_rdata),   32'(e.rdata));
          check("rsp_err",     32'(bus.rsp_err),     32'(e.err));
          check("rsp_timeout", 32'(bus.rsp_timeout), 32'(e.to));
          check("access_len",  32'(acc_len),         32'(e.acc));
          check("ready_at_rsp", 32'(bus.cmd_ready),  32'(1));
          check("psel_at_rsp",  32'(bus.PSEL),       32'(0));
        end
        acc_len = 0;
      end
    end else begin
      acc_len = 0;
    end
  end

  // Issue one command; called at posedge+1, returns at posedge+1 of the first ACCESS cycle
  task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [DW-1:0] er, input logic ee, input logic et, input int acc);
    exp_t e;
    int n;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cmd_ready && n < 100);
    if (!bus.cmd_ready) begin
      check("accept_timeout", 32'(0), 32'(1));
      return;
    end
    e = '{wr, a, d, er, ee, et, acc};
    sb.push_back(e);
    @(posedge clk); #1;
    prev_accept_t = accept_t;
    accept_t = longint'($time);
    check("psel_setup",      32'(bus.PSEL),      32'(1));
    check("penable_setup",   32'(bus.PENABLE),   32'(0));
    check("ready_low_setup", 32'(bus.cmd_ready), 32'(0));
    @(posedge clk); #1;
    check("penable_access",   32'(bus.PENABLE),   32'(1));
    check("psel_access",      32'(bus.PSEL),      32'(1));
    check("ready_low_access", 32'(bus.cmd_ready), 32'(0));
  endtask

  task automatic drain();
    int n;
    bus.cmd_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 32'(sb.size()), 32'(0));
    sb.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.PRDATA    = '0;
    bus.PSLVERR   = 1'b0;
    #1 rst_n = 1'b0;
    #10;
    check("rst_psel",      32'(bus.PSEL),      32'(0));
    check("rst_penable",   32'(bus.PENABLE),   32'(0));
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'(0));
    check("rst_paddr",     32'(bus.PADDR),     32'(0));
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", 32'(bus.cmd_ready), 32'(1));

    // Zero-wait write
    wait_cycles = 0;
    send(1'b1, 4'd2, 8'h5A, 8'h00, 1'b0, 1'b0, 1);
    drain();

    // Read with three wait states
    wait_cycles = 3;
    bus.PRDATA = 8'hC3;
    send(1'b0, 4'd6, 8'h11, 8'hC3, 1'b0, 1'b0, 4);
    drain();

    // Slave errors on read and write
    wait_cycles = 0;
    bus.PSLVERR = 1'b1;
    send(1'b0, 4'd12, 8'h22, 8'hC3, 1'b1, 1'b0, 1);
    drain();
    send(1'b1, 4'd5, 8'h33, 8'h00, 1'b1, 1'b0, 1);
    drain();
    bus.PSLVERR = 1'b0;

    // Stuck PREADY: abort after MAX_WAIT+1 ACCESS cycles, then a normal transfer
    wait_cycles = 100000;
    bus.PRDATA = 8'hAA;
    send(1'b0, 4'd9, 8'h44, 8'h00, 1'b1, 1'b1, int'(MW) + 1);
    drain();
    wait_cycles = 0;
    send(1'b1, 4'd3, 8'h77, 8'h00, 1'b0, 1'b0, 1);
    drain();

    // cmd_valid held high: back-to-back every 3 cycles
    wait_cycles = 0;
    send(1'b1, 4'd1, 8'h81, 8'h00, 1'b0, 1'b0, 1);
    for (int i = 0; i < 4; i++) begin
      send(1'b1, AW'(i + 8), DW'(8'h90 + i), 8'h00, 1'b0, 1'b0, 1);
      check("b2b_gap", 32'(accept_t - prev_accept_t), 32'(30));
    end
    drain();

    // Reset during ACCESS drops the transfer
    wait_cycles = 100000;
    send(1'b0, 4'd4, 8'h55, 8'h00, 1'b0, 1'b0, 1);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    #1;
    check("midrst_psel",      32'(bus.PSEL),      32'(0));
    check("midrst_penable",   32'(bus.PENABLE),   32'(0));
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    sb.delete();
    wait_cycles = 0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_midrst", 32'(bus.cmd_ready), 32'(1));
    repeat (3) @(posedge clk);
    #1;
    send(1'b1, 4'd7, 8'hE1, 8'h00, 1'b0, 1'b0, 1);
    drain();

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
